// File: rtl/ibex_pmp_csr_if.sv
// rtl/ibex_pmp_csr_if.sv - PMP CSR types and CSR access bus interface

package ibex_pmp_csr_pkg;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

endpackage

interface ibex_pmp_csr_if;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  modport master (
    output csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_hit_o
  );

  modport slave (
    input  csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_hit_o
  );
endinterface

// File: rtl/ibex_pmp_csr.sv
// rtl/ibex_pmp_csr.sv - PMP pmpcfg/pmpaddr/mseccfg CSR storage with WARL and lock rules

module ibex_pmp_csr
  import ibex_pmp_csr_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ibex_pmp_csr_if.slave       csr,
  output pmp_cfg_t            csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]         csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t        csr_pmp_mseccfg_o,
  output logic                pmp_updated_o
);

  // Low address bits forced to 0 (OFF/TOR) or 1 (NAPOT) on read-back.
  localparam logic [31:0] GRAN_MASK  = (32'h1 << PMPGranularity) - 32'h1;
  localparam logic [31:0] NAPOT_MASK = GRAN_MASK >> 1;

  pmp_cfg_t     cfg_q  [PMPNumRegions];
  pmp_cfg_t     cfg_d  [PMPNumRegions];
  logic [31:0]  addr_q [PMPNumRegions];
  logic [31:0]  addr_d [PMPNumRegions];
  pmp_mseccfg_t mseccfg_q, mseccfg_d;
  logic         pmp_updated_q, pmp_updated_d;

  logic is_cfg, is_addr, is_mseccfg, is_mseccfgh;
  logic [PMPNumRegions-1:0] entry_locked;
  logic [PMPNumRegions:0]   tor_locked;
  logic                     any_lock;
  logic [7:0]               wbyte;
  logic                     mml_block;
  logic [31:0]              rd_addr;

  assign is_cfg      = (csr.csr_addr_i[11:2] == 10'h0E8);
  assign is_addr     = (csr.csr_addr_i[11:4] == 8'h3B);
  assign is_mseccfg  = (csr.csr_addr_i == 12'h747);
  assign is_mseccfgh = (csr.csr_addr_i == 12'h757);
  assign csr.csr_hit_o = is_cfg | is_addr | is_mseccfg | is_mseccfgh;

  // Lock status of every entry, judged on the pre-write state.
  always_comb begin
    any_lock = 1'b0;
    tor_locked = '0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      entry_locked[i] = cfg_q[i].lock & ~mseccfg_q.rlb;
      tor_locked[i]   = entry_locked[i] & (cfg_q[i].mode == PMP_MODE_TOR);
      any_lock        = any_lock | cfg_q[i].lock;
    end
  end

  // Next register state for a CSR write, with WARL legalisation and lock checks.
  always_comb begin
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    mseccfg_d = mseccfg_q;
    wbyte     = '0;
    mml_block = 1'b0;
    if (csr.csr_we_i) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (is_cfg && (csr.csr_addr_i[1:0] == 2'(i / 4))) begin
          wbyte = csr.csr_wdata_i[8*(i%4) +: 8];
          // Under MML, locked executable or write-only rules cannot be added.
          mml_block = mseccfg_q.mml & ~mseccfg_q.rlb & wbyte[7] &
                      (wbyte[2] | (wbyte[1:0] == 2'b10));
          if (!entry_locked[i] && !mml_block) begin
            cfg_d[i].lock  = wbyte[7];
            cfg_d[i].mode  = pmp_cfg_mode_e'(wbyte[4:3]);
            cfg_d[i].exec  = wbyte[2];
            cfg_d[i].read  = wbyte[0];
            // W without R is reserved outside MML and reads back as no access.
            cfg_d[i].write = wbyte[1] & (wbyte[0] | mseccfg_q.mml);
            if ((PMPGranularity >= 1) && (wbyte[4:3] == 2'b10)) begin
              cfg_d[i].mode = PMP_MODE_OFF;
            end
          end
        end
        if (is_addr && (csr.csr_addr_i[3:0] == 4'(i))) begin
          if (!entry_locked[i] && !tor_locked[i+1]) begin
            addr_d[i] = csr.csr_wdata_i;
          end
        end
      end
      if (is_mseccfg) begin
        mseccfg_d.mml  = mseccfg_q.mml  | csr.csr_wdata_i[0];
        mseccfg_d.mmwp = mseccfg_q.mmwp | csr.csr_wdata_i[1];
        if (mseccfg_q.rlb || !any_lock) begin
          mseccfg_d.rlb = csr.csr_wdata_i[2];
        end
      end
    end
  end

  // Flag any stored bit that the write actually changes.
  always_comb begin
    pmp_updated_d = (mseccfg_d != mseccfg_q);
    for (int i = 0; i < PMPNumRegions; i++) begin
      pmp_updated_d = pmp_updated_d | (cfg_d[i] != cfg_q[i]) | (addr_d[i] != addr_q[i]);
    end
  end

  // Register state; reset clears everything including the update pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      mseccfg_q     <= '0;
      pmp_updated_q <= 1'b0;
    end else begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        cfg_q[i]  <= cfg_d[i];
        addr_q[i] <= addr_d[i];
      end
      mseccfg_q     <= mseccfg_d;
      pmp_updated_q <= pmp_updated_d;
    end
  end

  // Combinational read mux; pmpaddr read-back masking leaves the stored value intact.
  always_comb begin
    csr.csr_rdata_o = '0;
    rd_addr         = '0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      if (is_cfg && (csr.csr_addr_i[1:0] == 2'(i / 4))) begin
        csr.csr_rdata_o[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                         cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
      end
      if (is_addr && (csr.csr_addr_i[3:0] == 4'(i))) begin
        rd_addr = addr_q[i];
        if (cfg_q[i].mode == PMP_MODE_NAPOT) begin
          rd_addr = rd_addr | NAPOT_MASK;
        end
        if (!cfg_q[i].mode[1]) begin
          rd_addr = rd_addr & ~GRAN_MASK;
        end
        csr.csr_rdata_o = rd_addr;
      end
    end
    if (is_mseccfg) begin
      csr.csr_rdata_o = {29'b0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
    end
  end

  for (genvar g = 0; g < PMPNumRegions; g++) begin : g_out
    assign csr_pmp_cfg_o[g]  = cfg_q[g];
    assign csr_pmp_addr_o[g] = {addr_q[g], 2'b00};
  end

  assign csr_pmp_mseccfg_o = mseccfg_q;
  assign pmp_updated_o     = pmp_updated_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// tb/tb_ibex_pmp_csr.sv - self-checking bench for ibex_pmp_csr at granularity 0 and 2

module tb_ibex_pmp_csr;
  import ibex_pmp_csr_pkg::*;

  localparam int NUM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;

  always #5 clk = ~clk;

  ibex_pmp_csr_if bus0 ();
  ibex_pmp_csr_if bus2 ();

  assign bus0.csr_we_i = we;
  assign bus0.csr_addr_i = addr;
  assign bus0.csr_wdata_i = wdata;
  assign bus2.csr_we_i = we;
  assign bus2.csr_addr_i = addr;
  assign bus2.csr_wdata_i = wdata;

  pmp_cfg_t     cfg0 [NUM];
  pmp_cfg_t     cfg2 [NUM];
  logic [33:0]  ao0 [NUM];
  logic [33:0]  ao2 [NUM];
  pmp_mseccfg_t sec0, sec2;
  logic         upd0, upd2;

  ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(NUM)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .csr(bus0.slave),
    .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(ao0),
    .csr_pmp_mseccfg_o(sec0), .pmp_updated_o(upd0)
  );

  ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(NUM)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .csr(bus2.slave),
    .csr_pmp_cfg_o(cfg2), .csr_pmp_addr_o(ao2),
    .csr_pmp_mseccfg_o(sec2), .pmp_updated_o(upd2)
  );

  // Reference model: k=0 is the G=0 instance, k=1 the G=2 instance.
  logic [7:0]  m_cfg [2][16];
  logic [31:0] m_addr [2][16];
  logic        m_mml [2];
  logic        m_mmwp [2];
  logic        m_rlb [2];
  int          m_gran [2];
  logic        exp_upd [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] addr_list [26];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_upd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_cfg[k][i] = '0;
        m_addr[k][i] = '0;
      end
      m_mml[k] = 0;
      m_mmwp[k] = 0;
      m_rlb[k] = 0;
      exp_upd[k] = 0;
    end
  endfunction

  function automatic logic model_hit(input logic [11:0] a);
    int ai = int'(a);
    return (ai >= 'h3A0 && ai <= 'h3A3) || (ai >= 'h3B0 && ai <= 'h3BF) ||
           ai == 'h747 || ai == 'h757;
  endfunction

  // Apply one write to model k; returns whether any stored bit changed.
  function automatic logic model_write(input int k, input logic [11:0] a, input logic [31:0] d);
    int ai = int'(a);
    logic [7:0] oc [16];
    logic [31:0] oa [16];
    logic omml, ommwp, orlb, any_l, chg;
    logic [7:0] b, v;
    for (int i = 0; i < 16; i++) begin
      oc[i] = m_cfg[k][i];
      oa[i] = m_addr[k][i];
    end
    omml = m_mml[k]; ommwp = m_mmwp[k]; orlb = m_rlb[k];
    if (ai >= 'h3A0 && ai <= 'h3A3) begin
      for (int j = 0; j < 4; j++) begin
        int i = (ai - 'h3A0) * 4 + j;
        b = d[8*j +: 8];
        if (i < NUM) begin
          if (!(oc[i][7] && !orlb) &&
              !(omml && !orlb && b[7] && (b[2] || (b[0] == 0 && b[1] == 1)))) begin
            v = b & 8'h9F;
            if (!omml && v[0] == 0 && v[1] == 1) v[1] = 0;
            if (m_gran[k] >= 1 && v[4:3] == 2'b10) v[4:3] = 2'b00;
            m_cfg[k][i] = v;
          end
        end
      end
    end else if (ai >= 'h3B0 && ai <= 'h3BF) begin
      int i = ai - 'h3B0;
      if (i < NUM) begin
        logic blocked = oc[i][7] && !orlb;
        if (i + 1 < NUM && oc[i+1][4:3] == 2'b01 && oc[i+1][7] && !orlb) blocked = 1;
        if (!blocked) m_addr[k][i] = d;
      end
    end else if (ai == 'h747) begin
      any_l = 0;
      for (int i = 0; i < NUM; i++) if (oc[i][7]) any_l = 1;
      if (d[0]) m_mml[k] = 1;
      if (d[1]) m_mmwp[k] = 1;
      if (orlb || !any_l) m_rlb[k] = d[2];
    end
    chg = (omml != m_mml[k]) || (ommwp != m_mmwp[k]) || (orlb != m_rlb[k]);
    for (int i = 0; i < 16; i++) begin
      if (oc[i] != m_cfg[k][i] || oa[i] != m_addr[k][i]) chg = 1;
    end
    return chg;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [11:0] a);
    int ai = int'(a);
    logic [31:0] r = '0;
    if (ai >= 'h3A0 && ai <= 'h3A3) begin
      for (int j = 0; j < 4; j++) begin
        int i = (ai - 'h3A0) * 4 + j;
        if (i < NUM) r[8*j +: 8] = m_cfg[k][i];
      end
    end else if (ai >= 'h3B0 && ai <= 'h3BF) begin
      int i = ai - 'h3B0;
      if (i < NUM) begin
        logic [1:0] md = m_cfg[k][i][4:3];
        int g = m_gran[k];
        r = m_addr[k][i];
        if (g >= 2 && md == 2'b11) for (int j = 0; j <= g - 2; j++) r[j] = 1'b1;
        if (g >= 1 && md[1] == 1'b0) for (int j = 0; j < g; j++) r[j] = 1'b0;
      end
    end else if (ai == 'h747) begin
      r = {29'b0, m_rlb[k], m_mmwp[k], m_mml[k]};
    end
    return r;
  endfunction

  task automatic check_state();
    for (int k = 0; k < 2; k++) begin
      logic u;
      pmp_mseccfg_t s;
      u = (k == 0) ? upd0 : upd2;
      s = (k == 0) ? sec0 : sec2;
      chk($sformatf("upd%0d", k), 64'(u), 64'(exp_upd[k]));
      chk($sformatf("mseccfg%0d", k), 64'(s), 64'({m_rlb[k], m_mmwp[k], m_mml[k]}));
      for (int i = 0; i < NUM; i++) begin
        pmp_cfg_t c;
        logic [33:0] ad;
        c = (k == 0) ? cfg0[i] : cfg2[i];
        ad = (k == 0) ? ao0[i] : ao2[i];
        chk($sformatf("cfg_o%0d[%0d]", k, i),
            64'({c.lock, 2'b00, c.mode, c.exec, c.write, c.read}), 64'(m_cfg[k][i]));
        chk($sformatf("addr_o%0d[%0d]", k, i), 64'(ad), 64'({m_addr[k][i], 2'b00}));
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after commit.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    exp_upd[0] = model_write(0, a, d);
    exp_upd[1] = model_write(1, a, d);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    check_state();
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
    exp_upd[0] = 0;
    exp_upd[1] = 0;
    check_state();
  endtask

  task automatic read_both(input logic [11:0] a);
    addr = a;
    #1;
    chk($sformatf("rdata0 %h", a), 64'(bus0.csr_rdata_o), 64'(model_read(0, a)));
    chk($sformatf("rdata2 %h", a), 64'(bus2.csr_rdata_o), 64'(model_read(1, a)));
    chk($sformatf("hit %h", a), 64'({bus0.csr_hit_o, bus2.csr_hit_o}),
        64'({model_hit(a), model_hit(a)}));
  endtask

  // Assert reset between edges and check the outputs clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    read_both(12'h3A0);
    read_both(12'h747);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) addr_list[i] = 12'(12'h3A0 + i);
    for (int i = 0; i < 16; i++) addr_list[4+i] = 12'(12'h3B0 + i);
    addr_list[20] = 12'h747; addr_list[21] = 12'h757;
    addr_list[22] = 12'h3A4; addr_list[23] = 12'h3C0;
    addr_list[24] = 12'h746; addr_list[25] = 12'h000;
    m_gran[0] = 0;
    m_gran[1] = 2;

    vecs[0]  = '{12'h3A0, 32'h0000_0082, 32'h0000_0080, 1'b1};
    vecs[1]  = '{12'h3A0, 32'h0000_000F, 32'h0000_0080, 1'b0};
    vecs[2]  = '{12'h3A0, 32'h0000_8800, 32'h0000_8880, 1'b1};
    vecs[3]  = '{12'h3B0, 32'h0000_1000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{12'h747, 32'h0000_0004, 32'h0000_0000, 1'b0};
    vecs[5]  = '{12'h747, 32'h0000_0003, 32'h0000_0003, 1'b1};
    vecs[6]  = '{12'h747, 32'h0000_0000, 32'h0000_0003, 1'b0};
    vecs[7]  = '{12'h3A0, 32'h0084_0000, 32'h0000_8880, 1'b0};
    vecs[8]  = '{12'h3A0, 32'h8300_0000, 32'h8300_8880, 1'b1};
    vecs[9]  = '{12'h3A1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[10] = '{12'h757, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[11] = '{12'h3B2, 32'h0000_1234, 32'h0000_1234, 1'b1};

    model_reset();
    do_reset();

    // Reset state: every address reads zero, hit decode matches.
    for (int i = 0; i < 26; i++) begin
      read_both(addr_list[i]);
      chk($sformatf("rst_rd %h", addr_list[i]), 64'(bus0.csr_rdata_o), 64'h0);
    end
    idle();

    // Directed table on the G=0 instance.
    for (int v = 0; v < 12; v++) begin
      do_write(vecs[v].addr, vecs[v].wdata);
      chk($sformatf("tbl_upd[%0d]", v), 64'(upd0), 64'(vecs[v].exp_upd));
      addr = vecs[v].addr;
      #1;
      chk($sformatf("tbl_rd[%0d]", v), 64'(bus0.csr_rdata_o), 64'(vecs[v].exp_rdata));
      idle();
    end

    // Reset mid-pulse, then entry0 is writable again.
    do_reset();
    do_write(12'h3A0, 32'h0000_0080);
    chk("lock_pulse", 64'(upd0), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_upd", 64'(upd0), 64'h0);
    chk("async_cfg", 64'(cfg0[0]), 64'h0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    do_write(12'h3A0, 32'h0000_0001);
    addr = 12'h3A0;
    #1;
    chk("post_rst_cfg", 64'(bus0.csr_rdata_o), 64'h1);
    idle();

    // Granularity masking and NA4 handling.
    do_reset();
    do_write(12'h3B0, 32'hFFFF_FFFF);
    addr = 12'h3B0;
    #1;
    chk("g2_off_rd", 64'(bus2.csr_rdata_o), 64'hFFFF_FFFC);
    chk("g0_off_rd", 64'(bus0.csr_rdata_o), 64'hFFFF_FFFF);
    chk("g2_addr_o", 64'(ao2[0]), 64'h3_FFFF_FFFC);
    do_write(12'h3A0, 32'h0000_1018);
    addr = 12'h3A0;
    #1;
    chk("g2_na4", 64'(bus2.csr_rdata_o), 64'h0000_0018);
    chk("g0_na4", 64'(bus0.csr_rdata_o), 64'h0000_1018);
    do_write(12'h3B0, 32'h0000_0000);
    addr = 12'h3B0;
    #1;
    chk("g2_napot_rd", 64'(bus2.csr_rdata_o), 64'h0000_0001);
    chk("g2_napot_ao", 64'(ao2[0]), 64'h0);
    // Back-to-back effective writes give back-to-back pulses.
    do_write(12'h3B1, 32'h0000_0001);
    chk("b2b_first", 64'(upd0), 64'h1);
    do_write(12'h3B1, 32'h0000_0002);
    chk("b2b_second", 64'(upd0), 64'h1);
    idle();
    chk("b2b_drop", 64'(upd0), 64'h0);

    // Randomized writes against the model.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      logic [11:0] a;
      logic [31:0] d;
      if (it % 50 == 49) do_reset();
      a = addr_list[$urandom_range(0, 25)];
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d = d & 32'h7F7F7F7F;
      if (a == 12'h747 && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_FFFC;
      do_write(a, d);
      read_both(addr_list[$urandom_range(0, 25)]);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_csr.md
# ibex_pmp_csr

Machine-mode CSR storage for the Physical Memory Protection unit: holds pmpcfg/pmpaddr/mseccfg state and applies the WARL and lock rules, including the Smepmp MML/MMWP/RLB rules, on CSR writes. It serves CSR reads and drives the configuration buses that the PMP access checker consumes. It sits between the CSR instruction datapath and the PMP checker. It pulses a flag after every effective change so the core can flush fetched instructions.

## Interface
- PMPGranularity, 0: NAPOT granule, 2^(G+2) bytes; legal range 0..30.
- PMPNumRegions, 4: number of implemented entries; legal range 1..16.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- csr_we_i  in  1  write strobe; commits on the rising clock edge
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  write data
- csr_rdata_o  out  32  combinational read data of csr_addr_i
- csr_hit_o  out  1  csr_addr_i is 0x3A0–0x3A3, 0x3B0–0x3BF, 0x747 or 0x757
- csr_pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  registered entry configuration
- csr_pmp_addr_o  out  34 x PMPNumRegions  stored pmpaddr concatenated with 2'b00
- csr_pmp_mseccfg_o  out  pmp_mseccfg_t  registered {rlb, mmwp, mml}
- pmp_updated_o  out  1  one-cycle pulse after any register value change

## Operation
- Reset: all cfg fields, pmpaddr, mml, mmwp, rlb and pmp_updated_o are 0. Reset is asserted asynchronously and released synchronously to clk_i by the top level.
- pmpcfgN (0x3A0+N) holds entries 4N..4N+3, one per byte.
  - Byte layout: L[7], reserved[6:5], A[4:3], X[2], W[1], R[0].
  - Reserved bits are not stored and read as 0.
  - Unimplemented entries read 0 and ignore writes.
- pmpaddrI (0x3B0+I) stores bits [33:2] of the address.
- Entry i is locked when L[i]=1 and rlb=0.
- Each cfg byte is judged independently against the state before the write. A byte write to entry i is ignored when any of these holds:
  - entry i is locked;
  - mml=1, rlb=0, the written L=1, and the written byte has X=1 or {R,W}=01.
- Legalisation of an accepted cfg byte:
  - If mml=0 and {R,W}=01 is written, the stored value is {R,W}=00.
  - If PMPGranularity≥1, A=NA4 is stored as A=OFF.
- A pmpaddr i write is ignored when entry i is locked, or when entry i+1 exists, has A=TOR, and is locked.
- pmpaddr read-back:
  - If G≥2 and A=NAPOT, bits [G-2:0] read as 1.
  - If G≥1 and A is OFF or TOR, bits [G-1:0] read as 0.
  - The stored value is unchanged by this masking, and csr_pmp_addr_o always carries the stored value.
- mseccfg (0x747): bit0 mml, bit1 mmwp, bit2 rlb; other bits read 0.
  - mml and mmwp are sticky: a write of 1 sets the bit, a write of 0 is ignored, and only reset clears it.
  - A rlb write is ignored when rlb=0 and any implemented entry has L=1. Otherwise rlb takes wdata[2].
- mseccfgh (0x757) reads 0 and ignores writes.
- Addresses with csr_hit_o=0 read 0 and ignore writes. Illegal-instruction decisions belong to the CSR block.

## Timing
- Reads are combinational from the current registers.
- A write commits at the rising edge where csr_we_i=1. csr_rdata_o and all config outputs show the new value from the following cycle.
- pmp_updated_o:
  - It is registered and high for exactly one cycle, the same cycle the outputs first show the new value.
  - It is set only when some stored bit actually changes. A fully ignored write produces no pulse.
  - Back-to-back effective writes produce back-to-back pulses.
- A single write never depends on its own result. Examples, each judged against the pre-write state:
  - A pmpcfg write setting L and changing A in the same byte is accepted.
  - A later write to that entry is blocked.
- Reset asserted mid-sequence clears all state in the same cycle, independent of the clock. pmp_updated_o also drops immediately.

## Test plan
- Reset, then read every address: all reads return 0x0, csr_hit_o=1 on the listed addresses, pmp_updated_o=0.
- Write pmpcfg0=0x0000_0082 with mml=0: entry0 reads back 0x80, i.e. W is cleared and L is kept. A subsequent write of 0x0F to pmpcfg0 is ignored, and no pmp_updated_o pulse follows it.
- Write entry1 cfg=0x88 (L=1, TOR), then write pmpaddr0=0x1000: pmpaddr0 is unchanged. Next write mseccfg=0x4: rlb stays 0 and no pulse is produced.
- Instance with PMPGranularity=2: write pmpaddr0=0xFFFF_FFFF with entry0 OFF: readback is 0xFFFF_FFFC. Set entry0 to NAPOT, write pmpaddr0=0x0: readback is 0x0000_0001 and csr_pmp_addr_o[0]=34'h0.
- Write mseccfg=0x3, then mseccfg=0x0: mml=1 and mmwp=1 persist. Then write cfg 0x84 (L=1, X=1): it is ignored. cfg 0x83 (L=1, R=1, W=1) is accepted.
- Assert rst_ni low between clock edges after a lock sequence: all outputs read 0 before the next edge, and a following write to entry0 is accepted.
